// File: rtl/pm_frame_parser.sv
// pm_frame_parser: 42 4D framed sensor parser; publishes NCH 16-bit fields after length and checksum validate.
// Define PM_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles between bytes.
module pm_frame_parser #(
    parameter logic [7:0] HDR0        = 8'h42,
    parameter logic [7:0] HDR1        = 8'h4D,
    parameter int         FRAME_LEN   = 32,
    parameter int         FIELD_BASE  = 10,
    parameter int         NCH         = 3,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [16*NCH-1:0] ch_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [15:0]       err_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, LEN_HI, LEN_LO, BODY, CHK_HI, CHK_LO} state_t;

    state_t             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [15:0]        sum_q, sum_d;
    logic [7:0]         byte_q, byte_d;
    logic [16*NCH-1:0]  shadow_q, shadow_d, ch_q, ch_d;
    logic               fv_q, fv_d, fe_q, fe_d;
    logic [1:0]         code_q, code_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               discard, timeout;
    logic [1:0]         dcode;
    logic [15:0]        sum_add;

    assign sum_add = sum_q + 16'(rx_data);

`ifdef PM_TIMEOUT_EN
    logic [31:0] gap_q;
    assign timeout = state_q != IDLE && !rx_valid && gap_q == 32'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) gap_q <= '0;
        else     gap_q <= (state_q == IDLE || rx_valid) ? '0 : gap_q + 32'd1;
`else
    assign timeout = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        ch_d     = ch_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        code_d   = code_q;
        cnt_d    = cnt_q;
        discard  = 1'b0;
        dcode    = 2'd0;
        if (rx_valid) begin
            idx_d = idx_q + 7'd1;
            case (state_q)
                IDLE: if (rx_data == HDR0) begin
                    state_d = HDR;
                    sum_d   = {8'h00, HDR0};
                    idx_d   = 7'd1;
                end
                HDR: begin
                    state_d = rx_data == HDR1 ? LEN_HI : (rx_data == HDR0 ? HDR : IDLE);
                    sum_d   = rx_data == HDR0 ? {8'h00, HDR0} : sum_add;
                    idx_d   = rx_data == HDR0 ? 7'd1 : idx_q + 7'd1;
                end
                LEN_HI: begin
                    state_d = LEN_LO;
                    byte_d  = rx_data;
                    sum_d   = sum_add;
                end
                LEN_LO: begin
                    sum_d   = sum_add;
                    discard = {byte_q, rx_data} != 16'(FRAME_LEN - 4);
                    dcode   = 2'd1;
                    state_d = discard ? IDLE : BODY;
                end
                BODY: begin
                    sum_d = sum_add;
                    // channel byte j: MSB of channel j/2 when j is even
                    for (int j = 0; j < 2 * NCH; j++)
                        if (idx_q == 7'(FIELD_BASE + j))
                            shadow_d[16*(j/2) + 8*(1 - j%2) +: 8] = rx_data;
                    state_d = idx_q == 7'(FRAME_LEN - 3) ? CHK_HI : BODY;
                end
                CHK_HI: begin
                    state_d = CHK_LO;
                    byte_d  = rx_data;
                end
                CHK_LO: begin
                    state_d = IDLE;
                    fv_d    = {byte_q, rx_data} == sum_q;
                    ch_d    = fv_d ? shadow_q : ch_q;
                    discard = !fv_d;
                    dcode   = 2'd2;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            discard = state_q != HDR;
            dcode   = 2'd3;
        end
        if (discard) begin
            fe_d   = 1'b1;
            code_d = dcode;
            cnt_d  = cnt_q + {15'd0, cnt_q != 16'hFFFF};
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sum_q    <= '0;
            byte_q   <= '0;
            shadow_q <= '0;
            ch_q     <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            code_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
            ch_q     <= ch_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end

    assign ch_data     = ch_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign err_code    = code_q;
    assign err_cnt     = cnt_q;
endmodule

// File: doc/pm_frame_parser.md
Name: pm_frame_parser

Overview:
Parametrised byte-stream parser for particulate-sensor frames (0x42 0x4D header, big-endian 16-bit fields, 16-bit additive checksum). It consumes bytes from the UART receiver's byte-done strobe and extracts NCH consecutive 16-bit concentration fields. It publishes them atomically, and only after header, length and checksum all validate. It sits between the UART RX and the display/reporting logic.

Parameters:
HDR0, 8'h42, first header byte
HDR1, 8'h4D, second header byte
FRAME_LEN, 32, total frame bytes including header and checksum; range 8..64
FIELD_BASE, 10, byte offset of channel 0 MSB; even; FIELD_BASE>=4
NCH, 3, channels extracted; FIELD_BASE+2*NCH <= FRAME_LEN-2
TIMEOUT_CYC, 100000, max clk cycles between bytes inside a frame (PM_TIMEOUT_EN only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
rx_data  input  8  received byte
ch_data  output  16*NCH  channel k at [16k+15:16k] = {byte FIELD_BASE+2k, byte FIELD_BASE+2k+1}
frame_valid  output  1  one-cycle pulse: ch_data just updated
frame_err  output  1  one-cycle pulse: frame discarded
err_code  output  2  cause of last discard: 1 length, 2 checksum, 3 timeout; held until next discard
err_cnt  output  16  discarded-frame count, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE; ch_data, frame_valid, frame_err, err_code, err_cnt, internal byte index and sum all 0.
- Byte processing occurs only on cycles with rx_valid=1. All other inputs are ignored.
- States: IDLE, HDR, LEN_HI, LEN_LO, BODY, CHK_HI, CHK_LO.
- IDLE: byte==HDR0 -> HDR, sum=HDR0. Any other byte is ignored.
- HDR: byte==HDR1 -> LEN_HI. byte==HDR0 -> stay in HDR (resync, sum=HDR0). Otherwise -> IDLE. A bad header is not an error and produces no pulse.
- LEN_HI / LEN_LO: capture the 16-bit length. After LEN_LO, if length != FRAME_LEN-4, discard with code 1 -> IDLE. Otherwise -> BODY.
- BODY: byte indices 4..FRAME_LEN-3. Bytes in the channel window go to shadow registers, not ch_data. After index FRAME_LEN-3 -> CHK_HI.
- sum is the 16-bit wrap-around sum of bytes 0..FRAME_LEN-3, including header and length bytes.
- CHK_HI / CHK_LO: capture the received checksum, MSB first.
- On the cycle after the CHK_LO byte, compare received checksum with sum:
  - equal: copy shadow to ch_data and pulse frame_valid.
  - unequal: discard with code 2.
  - either way -> IDLE.
- Discard action: frame_err pulses one cycle, err_code is updated, err_cnt increments unless already 16'hFFFF.
- ch_data never shows a partial or failed frame; it holds the last good frame indefinitely.
- A HDR0 byte inside a frame is treated as data. There is no mid-frame resync.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a header byte arriving on the cycle after CHK_LO is accepted, since the publish/compare does not block IDLE.
- Reset mid-frame: partial frame lost; ch_data returns to 0.

Optional Feature:
PM_TIMEOUT_EN: when defined, a gap counter runs in every state except IDLE and clears on each rx_valid. Reaching TIMEOUT_CYC discards with code 3 -> IDLE. For a gap in HDR, the parser returns to IDLE silently with no error. When undefined, there is no counter, code 3 never occurs, and the parser waits indefinitely.

Test Plan:
- Valid frame (defaults): 42 4D 00 1C, bytes 4..9=00, bytes 10..15=00 0A 00 14 00 1E, bytes 16..29=00, checksum 00 E7 -> one frame_valid pulse; ch_data[15:0]=10, [31:16]=20, [47:32]=30; err_cnt=0.
- Same frame with checksum 00 E8 -> frame_err pulse, err_code=2, err_cnt=1, ch_data unchanged from the previous good frame.
- Bytes 42 42 4D then the valid frame remainder -> accepted (header resync), frame_valid pulse. Lone 37 55 before 42 -> ignored, no error.
- Length field 00 1D -> frame_err on LEN_LO, err_code=1. A following valid frame parses correctly.
- Frame with 200-cycle gaps between bytes, then rst asserted at byte 12 -> all outputs 0 immediately. A subsequent valid frame is accepted.
- PM_TIMEOUT_EN with TIMEOUT_CYC=50: stop after byte 8 -> frame_err at gap cycle 50, err_code=3. Without the macro, no pulse occurs.
